// File: rtl/fft_ctrl_if.sv
// Control/address bundle between the FFT sequencer and the butterfly datapath.
// master: the sequencer (fft_ctrl). slave: the datapath/RAM side that issues start.
interface fft_ctrl_if #(
  parameter int unsigned LOG2N = 5
);
  localparam int unsigned SW = $clog2(LOG2N);

  logic             start;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic             ro_valid;
  logic [LOG2N-1:0] ro_idx;

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, ro_valid, ro_idx
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, ro_valid, ro_idx
  );
endinterface

// File: rtl/fft_ctrl.sv
// Radix-2 DIF in-place FFT sequencer: one butterfly address pair per cycle,
// write-back addresses delayed by the butterfly pipeline latency.
// Optional macro FFT_CTRL_BITREV_EN adds an UNLOAD phase that reads the result
// out in natural order; without it ro_valid/ro_idx are tied low.
module fft_ctrl #(
  parameter int unsigned LOG2N    = 5,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  fft_ctrl_if.master bus
);
  localparam int unsigned AW = LOG2N;
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [AW-1:0] K_LAST = AW'((1 << KW) - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
`ifdef FFT_CTRL_BITREV_EN
  localparam logic [AW-1:0] N_LAST = AW'((1 << AW) - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, UNLOAD, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif

  state_t        state;
  logic [SW-1:0] s;
  logic [AW-1:0] cnt;
  logic [DW-1:0] dcnt;

  // Low bits below the inserted bit position LOG2N-1-s; also span-1.
  function automatic logic [AW-1:0] lo_mask(input logic [SW-1:0] s_i);
    return {AW{1'b1}} >> (32'(s_i) + 32'd1);
  endfunction

  // k with a 0 inserted at bit LOG2N-1-s.
  function automatic logic [AW-1:0] addr_a(input logic [SW-1:0] s_i, input logic [KW-1:0] k_i);
    logic [AW-1:0] kk;
    logic [AW-1:0] m;
    kk = AW'(k_i);
    m  = lo_mask(s_i);
    return ((kk & ~m) << 1) | (kk & m);
  endfunction

  // Partner address: a + span.
  function automatic logic [AW-1:0] addr_b(input logic [SW-1:0] s_i, input logic [KW-1:0] k_i);
    return addr_a(s_i, k_i) | (lo_mask(s_i) + AW'(1));
  endfunction

  // (k mod span) << s.
  function automatic logic [KW-1:0] tw_of(input logic [SW-1:0] s_i, input logic [KW-1:0] k_i);
    logic [AW-1:0] kk;
    kk = AW'(k_i) & lo_mask(s_i);
    return KW'(kk << s_i);
  endfunction

`ifdef FFT_CTRL_BITREV_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int j = 0; j < int'(AW); j++) r[j] = v[AW-1-j];
    return r;
  endfunction
`endif

  assign bus.stage = s;

  // Sequencer FSM with registered read-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      s             <= '0;
      cnt           <= '0;
      dcnt          <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr_a <= '0;
      bus.rd_addr_b <= '0;
      bus.tw_addr   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= RUN;
            s             <= '0;
            cnt           <= '0;
            bus.busy      <= 1'b1;
            bus.rd_en     <= 1'b1;
            bus.rd_addr_a <= addr_a('0, '0);
            bus.rd_addr_b <= addr_b('0, '0);
            bus.tw_addr   <= tw_of('0, '0);
          end
        end
        RUN: begin
          if (cnt == K_LAST) begin
            state         <= DRAIN;
            dcnt          <= '0;
            bus.rd_en     <= 1'b0;
            bus.rd_addr_a <= '0;
            bus.rd_addr_b <= '0;
            bus.tw_addr   <= '0;
          end else begin
            cnt           <= cnt + AW'(1);
            bus.rd_addr_a <= addr_a(s, KW'(cnt + AW'(1)));
            bus.rd_addr_b <= addr_b(s, KW'(cnt + AW'(1)));
            bus.tw_addr   <= tw_of(s, KW'(cnt + AW'(1)));
          end
        end
        DRAIN: begin
          if (dcnt != D_LAST) begin
            dcnt <= dcnt + DW'(1);
          end else if (s != S_LAST) begin
            state         <= RUN;
            s             <= s + SW'(1);
            cnt           <= '0;
            bus.rd_en     <= 1'b1;
            bus.rd_addr_a <= addr_a(s + SW'(1), '0);
            bus.rd_addr_b <= addr_b(s + SW'(1), '0);
            bus.tw_addr   <= tw_of(s + SW'(1), '0);
          end else begin
`ifdef FFT_CTRL_BITREV_EN
            state         <= UNLOAD;
            cnt           <= '0;
            bus.rd_en     <= 1'b1;
            bus.rd_addr_a <= bitrev('0);
            bus.rd_addr_b <= '0;
`else
            state         <= DONE;
            s             <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
`endif
          end
        end
`ifdef FFT_CTRL_BITREV_EN
        UNLOAD: begin
          if (cnt == N_LAST) begin
            state         <= DONE;
            s             <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.rd_en     <= 1'b0;
            bus.rd_addr_a <= '0;
          end else begin
            cnt           <= cnt + AW'(1);
            bus.rd_addr_a <= bitrev(cnt + AW'(1));
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write-back delay line; only butterfly reads produce writes.
  logic [PIPE_LAT-1:0] pe;
  logic [AW-1:0]       pa [PIPE_LAT];
  logic [AW-1:0]       pb [PIPE_LAT];
  logic                bfly;

  assign bfly = bus.rd_en && (state == RUN);

  // Shift read pair through PIPE_LAT stages to form the write pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe <= '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      pe[0] <= bfly;
      pa[0] <= bfly ? bus.rd_addr_a : '0;
      pb[0] <= bfly ? bus.rd_addr_b : '0;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        pe[i] <= pe[i-1];
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  assign bus.wr_en     = pe[PIPE_LAT-1];
  assign bus.wr_addr_a = pa[PIPE_LAT-1];
  assign bus.wr_addr_b = pb[PIPE_LAT-1];

`ifdef FFT_CTRL_BITREV_EN
  // Unload index lags the read by the one-cycle RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ro_valid <= 1'b0;
      bus.ro_idx   <= '0;
    end else begin
      bus.ro_valid <= bus.rd_en && (state == UNLOAD);
      bus.ro_idx   <= (state == UNLOAD) ? cnt : '0;
    end
  end
`else
  assign bus.ro_valid = 1'b0;
  assign bus.ro_idx   = '0;
`endif
endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: per-cycle comparison against a transaction-level
// model of the transform schedule, plus literal expectations for an N=8 transform.
module tb_fft_ctrl;
  localparam int unsigned L  = 3;
  localparam int unsigned P  = 2;
  localparam int unsigned N  = 1 << L;
  localparam int unsigned KW = L - 1;
  localparam int unsigned SW = $clog2(L);

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          rd_en;
    logic          bfly;
    logic          unl;
    logic [SW-1:0] stage;
    logic [L-1:0]  a;
    logic [L-1:0]  b;
    logic [KW-1:0] tw;
    logic [L-1:0]  i;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft_ctrl_if #(.LOG2N(L)) bus ();

  fft_ctrl #(.LOG2N(L), .PIPE_LAT(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  ent_t         q[$];
  ent_t         cur = '0;
  logic         hen [P];
  logic [L-1:0] ha  [P];
  logic [L-1:0] hb  [P];
  logic         ro_v = 1'b0;
  logic [L-1:0] ro_i = '0;

  function automatic int rev(input int x);
    int r = 0;
    int v = x;
    for (int j = 0; j < int'(L); j++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Whole-transform schedule: one entry per cycle from the first RUN cycle on.
  task automatic gen();
    ent_t e;
    int   span;
    int   a;
    for (int s = 0; s < int'(L); s++) begin
      span = int'(N) >> (s + 1);
      for (int k = 0; k < int'(N) / 2; k++) begin
        a = (k / span) * 2 * span + (k % span);
        e = '0;
        e.busy = 1'b1; e.rd_en = 1'b1; e.bfly = 1'b1;
        e.stage = SW'(s);
        e.a = L'(a); e.b = L'(a + span);
        e.tw = KW'((k % span) << s);
        q.push_back(e);
      end
      for (int d = 0; d < int'(P); d++) begin
        e = '0; e.busy = 1'b1; e.stage = SW'(s);
        q.push_back(e);
      end
    end
`ifdef FFT_CTRL_BITREV_EN
    for (int i = 0; i < int'(N); i++) begin
      e = '0; e.busy = 1'b1; e.rd_en = 1'b1; e.unl = 1'b1;
      e.stage = SW'(L - 1); e.a = L'(rev(i)); e.i = L'(i);
      q.push_back(e);
    end
`endif
    e = '0; e.done = 1'b1; q.push_back(e);
    e = '0; q.push_back(e);   // forced idle cycle: start in DONE is dropped
  endtask

  initial begin
    for (int j = 0; j < int'(P); j++) begin hen[j] = 1'b0; ha[j] = '0; hb[j] = '0; end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        cur = '0; ro_v = 1'b0; ro_i = '0;
        for (int j = 0; j < int'(P); j++) begin hen[j] = 1'b0; ha[j] = '0; hb[j] = '0; end
      end else begin
        for (int j = int'(P) - 1; j > 0; j--) begin
          hen[j] = hen[j-1]; ha[j] = ha[j-1]; hb[j] = hb[j-1];
        end
        hen[0] = cur.rd_en & cur.bfly;
        ha[0]  = hen[0] ? cur.a : '0;
        hb[0]  = hen[0] ? cur.b : '0;
        ro_v   = cur.unl;
        ro_i   = cur.unl ? cur.i : '0;
        if (q.size() != 0) cur = q.pop_front();
        else if (bus.start) begin gen(); cur = q.pop_front(); end
        else cur = '0;
      end
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic cap = 1'b0;
  int   busy_cnt = 0, done_cnt = 0, wr_cnt = 0, overlap = 0;
  logic prev_rd = 1'b0;
  int   obs_a[$], obs_b[$], obs_t[$];

  initial forever begin
    @(negedge clk);
    check("busy",      32'(bus.busy),      32'(cur.busy));
    check("done",      32'(bus.done),      32'(cur.done));
    check("stage",     32'(bus.stage),     32'(cur.stage));
    check("rd_en",     32'(bus.rd_en),     32'(cur.rd_en));
    check("rd_addr_a", 32'(bus.rd_addr_a), 32'(cur.a));
    check("rd_addr_b", 32'(bus.rd_addr_b), 32'(cur.b));
    check("tw_addr",   32'(bus.tw_addr),   32'(cur.tw));
    check("wr_en",     32'(bus.wr_en),     32'(hen[P-1]));
    check("wr_addr_a", 32'(bus.wr_addr_a), 32'(ha[P-1]));
    check("wr_addr_b", 32'(bus.wr_addr_b), 32'(hb[P-1]));
    check("ro_valid",  32'(bus.ro_valid),  32'(ro_v));
    check("ro_idx",    32'(bus.ro_idx),    32'(ro_i));
    if (cap) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.wr_en) wr_cnt++;
      if (bus.rd_en && !prev_rd && bus.wr_en) overlap++;
      if (bus.rd_en) begin
        obs_a.push_back(int'(bus.rd_addr_a));
        obs_b.push_back(int'(bus.rd_addr_b));
        obs_t.push_back(int'(bus.tw_addr));
      end
    end
    prev_rd = bus.rd_en;
  end

  function automatic logic [31:0] outs();
    return 32'({bus.busy, bus.done, bus.stage, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
                bus.tw_addr, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b, bus.ro_valid, bus.ro_idx});
  endfunction

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", 32'(n < budget), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int lit_tab [12][3] = '{'{0,4,0}, '{1,5,1}, '{2,6,2}, '{3,7,3},
                          '{0,2,0}, '{1,3,2}, '{4,6,0}, '{5,7,2},
                          '{0,1,0}, '{2,3,0}, '{4,5,0}, '{6,7,0}};

  initial begin
    int dn;
    int n;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_zero", outs(), 32'd0);
    #1 rst = 1'b0;

    // Single start pulse, N=8 literal schedule.
    @(negedge clk);
    cap = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(60);
    @(negedge clk);
    cap = 1'b0;
    check("busy_cycles", 32'(busy_cnt), 32'd18);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("rd_count",    32'(obs_a.size()), 32'd12);
    check("wr_count",    32'(wr_cnt), 32'd12);
    check("wr_in_first_read", 32'(overlap), 32'd0);
    for (int j = 0; j < 12 && j < obs_a.size(); j++) begin
      check("lit_a",  32'(obs_a[j]), 32'(lit_tab[j][0]));
      check("lit_b",  32'(obs_b[j]), 32'(lit_tab[j][1]));
      check("lit_tw", 32'(obs_t[j]), 32'(lit_tab[j][2]));
    end

    // Start held through a whole transform: exactly one run.
    bus.start = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    bus.start = 1'b0;
    check("held_start_done", 32'(dn), 32'd1);
    @(negedge clk);
    check("held_start_idle", 32'(bus.busy), 32'd0);

    // Reset on the 3rd RUN cycle of stage 1.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.stage == SW'(1) && bus.rd_en) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_stage1", 32'(n < 40), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_zero", outs(), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.rd_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("restart_stage", 32'(bus.stage), 32'd0);
    check("restart_a",     32'(bus.rd_addr_a), 32'd0);
    check("restart_b",     32'(bus.rd_addr_b), 32'd4);
    wait_done(60);
    repeat (2) @(negedge clk);

    // Randomized start/reset traffic against the model.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      #1;
      rst = ($urandom_range(0, 249) == 0);
      bus.start = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
